// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI slave types and constants (state enum, byte width).
package spi_pkg;
  localparam int BitsPerByte = 8;
  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    SHIFT
  } spi_tx_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer plus an edge-detect flop.
// Ports: clk_i/rst_ni system clock and sync active-low reset; d_i asynchronous input;
// level_o synchronized level; rise_o/fall_o one-cycle edge strobes.
module spi_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], d_i};
  always_ff @(posedge clk_i) sync_q <= !rst_ni ? {3{ResetVal}} : sync_d;
  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: oversampled SPI slave MISO transmitter, MSB first, fed from a byte stream.
// Ports: clk_i/rst_ni system clock and sync active-low reset; spi_slave_clk_i/spi_slave_cs_i
// external SCK and active-low CS; spi_slave_miso_o/_oe_o serial data and pad enable;
// tx_data_i/tx_valid_i/tx_ready_o byte stream (tx_ready_o is the pop strobe);
// byte_done_o/underrun_o/abort_o status pulses; busy_o frame in progress.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter bit         CPOL         = 1'b0,
  parameter bit         CPHA         = 1'b0,
  parameter logic       IdleLevel    = 1'b1,
  parameter logic [7:0] UnderrunByte = 8'hFF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   spi_slave_clk_i,
  input  logic                   spi_slave_cs_i,
  output logic                   spi_slave_miso_o,
  output logic                   spi_slave_miso_oe_o,
  input  logic [BitsPerByte-1:0] tx_data_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  output logic                   byte_done_o,
  output logic                   underrun_o,
  output logic                   abort_o,
  output logic                   busy_o
);
  localparam int CntW = $clog2(BitsPerByte);
  spi_tx_state_e state_q, state_d;
  logic [BitsPerByte-1:0] shreg_q, shreg_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic miso_q, miso_d, oe_q, oe_d;
  logic unused_sck_lvl, unused_cs_lvl, sck_rise, sck_fall, cs_rise, cs_fall;
  logic lead, trail, drive, sample, last_bit, load, shift;
  spi_sync_edge #(.ResetVal(CPOL)) u_sck (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_slave_clk_i),
    .level_o(unused_sck_lvl),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );
  spi_sync_edge #(.ResetVal(1'b1)) u_cs (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_slave_cs_i),
    .level_o(unused_cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );
  assign lead     = CPOL ? sck_fall : sck_rise;
  assign trail    = CPOL ? sck_rise : sck_fall;
  assign drive    = CPHA ? lead : trail;
  assign sample   = CPHA ? trail : lead;
  assign last_bit = bit_cnt_q == CntW'(BitsPerByte - 1);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      miso_q    <= IdleLevel;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
    end
  end
  // CS rise overrides every SCK event in the same cycle.
  always_comb begin
    state_d = (cs_rise && state_q != IDLE) ? IDLE
            : (state_q == IDLE && cs_fall) ? (CPHA ? LOAD_WAIT : SHIFT)
            : (state_q == LOAD_WAIT && drive) ? SHIFT
            : (state_q == SHIFT && sample && last_bit) ? LOAD_WAIT
            : state_q;
    shreg_d   = load ? (tx_valid_i ? tx_data_i : UnderrunByte)
              : shift ? {shreg_q[BitsPerByte-2:0], 1'b0} : shreg_q;
    bit_cnt_d = (state_q == IDLE || cs_rise) ? '0
              : (state_q == SHIFT && sample) ? bit_cnt_q + CntW'(1) : bit_cnt_q;
    miso_d    = state_q == IDLE ? IdleLevel : shreg_q[BitsPerByte-1];
    oe_d      = state_q != IDLE;
  end
  // Pulses are gated by reset so nothing is popped or reported while rst_ni is low.
  always_comb begin
    load        = rst_ni && !cs_rise && (state_q == IDLE ? (cs_fall && !CPHA)
                                                         : (state_q == LOAD_WAIT && drive));
    shift       = !cs_rise && state_q == SHIFT && drive && bit_cnt_q != '0;
    tx_ready_o  = load && tx_valid_i;
    underrun_o  = load && !tx_valid_i;
    byte_done_o = rst_ni && !cs_rise && state_q == SHIFT && sample && last_bit;
    abort_o     = rst_ni && cs_rise && state_q != IDLE && bit_cnt_q != '0;
    busy_o      = state_q != IDLE;
  end
  assign spi_slave_miso_o    = miso_q;
  assign spi_slave_miso_oe_o = oe_q;
endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: SPI master model driving all four modes of spi_slave_tx against a byte-stream model.
module tb_spi_slave_tx;
  localparam int H = 4;
  typedef struct packed {
    logic [31:0] rx;
    logic [7:0]  pre;
    logic [7:0]  rdy;
    logic [7:0]  ur;
    logic [7:0]  bd;
    logic [7:0]  ab;
    logic        oe_ok;
  } obs_t;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [3:0] sck = 4'b1100;
  logic [3:0] cs = 4'hF;
  logic [3:0] miso, oe, rdy, bd, ur, ab, busy;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic [7:0] fifo[$];
  logic [7:0] exp_q[$];
  int checks = 0, errors = 0;
  int n_rdy = 0, n_ur = 0, n_bd = 0, n_ab = 0, n_viol = 0;
  always #10 clk = ~clk;
  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave_tx #(.CPOL(1'(m / 2)), .CPHA(1'(m % 2))) u_dut (
      .clk_i              (clk),
      .rst_ni             (rst_ni),
      .spi_slave_clk_i    (sck[m]),
      .spi_slave_cs_i     (cs[m]),
      .spi_slave_miso_o   (miso[m]),
      .spi_slave_miso_oe_o(oe[m]),
      .tx_data_i          (tx_data),
      .tx_valid_i         (tx_valid),
      .tx_ready_o         (rdy[m]),
      .byte_done_o        (bd[m]),
      .underrun_o         (ur[m]),
      .abort_o            (ab[m]),
      .busy_o             (busy[m])
    );
  end
  always @(posedge clk) begin
    n_rdy  <= n_rdy + $countones(rdy);
    n_ur   <= n_ur + $countones(ur);
    n_bd   <= n_bd + $countones(bd);
    n_ab   <= n_ab + $countones(ab);
    n_viol <= n_viol + $countones(rdy & ~{4{tx_valid}});
    if (|rdy && fifo.size() != 0) void'(fifo.pop_front());
  end
  always @(negedge clk) begin
    tx_valid = fifo.size() != 0;
    tx_data  = tx_valid ? fifo[0] : 8'h00;
  end
  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    exp_q.push_back(b);
  endtask
  task automatic set_sck(input int md, input bit lvl);
    sck[md] = lvl ^ 1'(md / 2);
  endtask
  task automatic frame(input int md, input int nbits, input bit rol, output obs_t o);
    int r0, u0, b0, a0;
    bit cpha, last;
    cpha = 1'(md % 2);
    o = '0;
    o.oe_ok = 1'b1;
    r0 = n_rdy; u0 = n_ur; b0 = n_bd; a0 = n_ab;
    cs[md] = 1'b0;
    repeat (H) @(negedge clk);
    o.pre = 8'(n_rdy - r0);
    for (int i = 0; i < nbits; i++) begin
      last = rol && i == nbits - 1;
      if (!cpha) begin
        o.rx = {o.rx[30:0], miso[md]};
        o.oe_ok &= oe[md];
        set_sck(md, 1'b1);
        if (last) cs[md] = 1'b1;
        repeat (H) @(negedge clk);
        if (!last) begin
          set_sck(md, 1'b0);
          repeat (H) @(negedge clk);
        end
      end else begin
        set_sck(md, 1'b1);
        repeat (H) @(negedge clk);
        o.rx = {o.rx[30:0], miso[md]};
        o.oe_ok &= oe[md];
        set_sck(md, 1'b0);
        if (last) cs[md] = 1'b1;
        repeat (H) @(negedge clk);
      end
    end
    cs[md] = 1'b1;
    set_sck(md, 1'b0);
    repeat (8) @(negedge clk);
    o.rdy = 8'(n_rdy - r0);
    o.ur  = 8'(n_ur - u0);
    o.bd  = 8'(n_bd - b0);
    o.ab  = 8'(n_ab - a0);
  endtask
  // Load points: CPHA=0 loads at CS fall and after every completed byte; CPHA=1 at every byte's first lead edge.
  task automatic model(input int md, input int nbits, input bit rol, output obs_t e);
    int k, loads;
    logic [63:0] s;
    logic [7:0] b;
    bit cpha;
    cpha = 1'(md % 2);
    k = nbits - int'(rol);
    loads = cpha ? (nbits + 7) / 8 : 1 + k / 8;
    e = '0;
    e.oe_ok = 1'b1;
    s = '0;
    e.pre = (!cpha && exp_q.size() != 0) ? 8'd1 : 8'd0;
    for (int l = 0; l < loads; l++) begin
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        e.rdy = e.rdy + 8'd1;
      end else begin
        b = 8'hFF;
        e.ur = e.ur + 8'd1;
      end
      s = {s[55:0], b};
    end
    e.rx = 32'(s >> (8 * loads - nbits));
    e.bd = 8'(k / 8);
    e.ab = (k % 8 != 0) ? 8'd1 : 8'd0;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({miso, oe, busy, rdy, bd, ur, ab} !== {4'hF, 24'h0}) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", {miso, oe, busy, rdy, bd, ur, ab}, {4'hF, 24'h0});
    end
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({miso, oe, busy, rdy, bd, ur, ab} !== {4'hF, 24'h0}) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", {miso, oe, busy, rdy, bd, ur, ab}, {4'hF, 24'h0});
    end
  endtask
  task automatic test_mode0_stream;
    obs_t o, e;
    push(8'hA5);
    push(8'h3C);
    model(0, 16, 1'b0, e);
    frame(0, 16, 1'b0, o);
    checks++;
    if (o.rx !== 32'h0000A53C) begin
      errors++;
      $display("FAIL mode0_rx: got %h expected %h", o.rx, 32'h0000A53C);
    end
    checks++;
    if ({o.rdy, o.bd} !== {8'd2, 8'd2}) begin
      errors++;
      $display("FAIL mode0_ready_done: got %h expected %h", {o.rdy, o.bd}, {8'd2, 8'd2});
    end
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL mode0_model: got %h expected %h", o, e);
    end
    checks++;
    if ({miso[0], oe[0], busy[0]} !== 3'b100) begin
      errors++;
      $display("FAIL mode0_idle: got %b expected %b", {miso[0], oe[0], busy[0]}, 3'b100);
    end
  endtask
  task automatic test_modes;
    obs_t o, e;
    for (int md = 1; md < 4; md++) begin
      push(8'h81);
      model(md, 8, 1'b0, e);
      frame(md, 8, 1'b0, o);
      checks++;
      if (o.rx !== 32'h81) begin
        errors++;
        $display("FAIL mode%0d_rx: got %h expected %h", md, o.rx, 32'h81);
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mode%0d_model: got %h expected %h", md, o, e);
      end
    end
  endtask
  task automatic test_underrun;
    obs_t o, e;
    model(3, 16, 1'b0, e);
    frame(3, 16, 1'b0, o);
    checks++;
    if ({o.rx, o.rdy, o.ur} !== {32'h0000FFFF, 8'd0, 8'd2}) begin
      errors++;
      $display("FAIL underrun: got %h expected %h", {o.rx, o.rdy, o.ur}, {32'h0000FFFF, 8'd0, 8'd2});
    end
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL underrun_model: got %h expected %h", o, e);
    end
  endtask
  task automatic test_abort;
    obs_t o, e;
    push(8'hF0);
    push(8'h0F);
    model(0, 3, 1'b0, e);
    frame(0, 3, 1'b0, o);
    checks++;
    if ({o.rx, o.ab, o.bd} !== {32'h7, 8'd1, 8'd0}) begin
      errors++;
      $display("FAIL abort_pulse: got %h expected %h", {o.rx, o.ab, o.bd}, {32'h7, 8'd1, 8'd0});
    end
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL abort_model: got %h expected %h", o, e);
    end
    checks++;
    if ({miso[0], oe[0], busy[0]} !== 3'b100) begin
      errors++;
      $display("FAIL abort_idle: got %b expected %b", {miso[0], oe[0], busy[0]}, 3'b100);
    end
    model(0, 8, 1'b0, e);
    frame(0, 8, 1'b0, o);
    checks++;
    if (o.rx !== 32'h0F) begin
      errors++;
      $display("FAIL abort_next_byte: got %h expected %h", o.rx, 32'h0F);
    end
  endtask
  task automatic test_reset_mid;
    obs_t o, e;
    int r0, a0, b0;
    push(8'h55);
    push(8'h66);
    r0 = n_rdy; a0 = n_ab; b0 = n_bd;
    cs[0] = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      set_sck(0, 1'b1);
      repeat (H) @(negedge clk);
      set_sck(0, 1'b0);
      repeat (H) @(negedge clk);
    end
    rst_ni = 1'b0;
    cs[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({miso[0], oe[0], busy[0], rdy[0], bd[0], ur[0], ab[0]} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_mid_state: got %b expected %b", {miso[0], oe[0], busy[0], rdy[0], bd[0], ur[0], ab[0]}, 7'b1000000);
    end
    rst_ni = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if ({8'(n_rdy - r0), 8'(n_ab - a0), 8'(n_bd - b0), busy[0]} !== {8'd1, 8'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_pulses: got %h expected %h", {8'(n_rdy - r0), 8'(n_ab - a0), 8'(n_bd - b0), busy[0]}, {8'd1, 8'd0, 8'd0, 1'b0});
    end
    void'(exp_q.pop_front());
    model(0, 8, 1'b0, e);
    frame(0, 8, 1'b0, o);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_mid_next: got %h expected %h", o, e);
    end
  endtask
  task automatic test_cs_inactive;
    int r0, u0, b0, a0;
    push(8'h77);
    r0 = n_rdy; u0 = n_ur; b0 = n_bd; a0 = n_ab;
    for (int md = 0; md < 4; md++)
      for (int i = 0; i < 8; i++) begin
        set_sck(md, 1'b1);
        repeat (H) @(negedge clk);
        set_sck(md, 1'b0);
        repeat (H) @(negedge clk);
      end
    repeat (8) @(negedge clk);
    checks++;
    if ({n_rdy - r0, n_ur - u0, n_bd - b0, n_ab - a0} !== 128'h0) begin
      errors++;
      $display("FAIL cs_inactive_pulses: got %h expected %h", {n_rdy - r0, n_ur - u0, n_bd - b0, n_ab - a0}, 128'h0);
    end
    checks++;
    if ({miso, oe, busy} !== 12'hF00) begin
      errors++;
      $display("FAIL cs_inactive_idle: got %h expected %h", {miso, oe, busy}, 12'hF00);
    end
  endtask
  task automatic test_cs_rise_sample;
    obs_t o, e;
    model(0, 8, 1'b1, e);
    frame(0, 8, 1'b1, o);
    checks++;
    if ({o.rx, o.bd, o.ab} !== {32'h77, 8'd0, 8'd1}) begin
      errors++;
      $display("FAIL rise_sample_abort: got %h expected %h", {o.rx, o.bd, o.ab}, {32'h77, 8'd0, 8'd1});
    end
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL rise_sample_model: got %h expected %h", o, e);
    end
    model(2, 9, 1'b1, e);
    frame(2, 9, 1'b1, o);
    checks++;
    if ({o.bd, o.ab} !== {8'd1, 8'd0} || o !== e) begin
      errors++;
      $display("FAIL rise_sample_boundary: got %h expected %h", o, e);
    end
    model(3, 1, 1'b1, e);
    frame(3, 1, 1'b1, o);
    checks++;
    if ({o.bd, o.ab} !== {8'd0, 8'd0} || o !== e) begin
      errors++;
      $display("FAIL rise_sample_nothing: got %h expected %h", o, e);
    end
  endtask
  task automatic test_random;
    obs_t o, e;
    int md, nbits, nq;
    bit rol;
    for (int it = 0; it < 12; it++) begin
      md = int'($urandom_range(0, 3));
      nbits = int'($urandom_range(1, 24));
      rol = 1'($urandom_range(0, 1));
      nq = int'($urandom_range(0, 3));
      for (int q = 0; q < nq; q++) push(8'($urandom));
      model(md, nbits, rol, e);
      frame(md, nbits, rol, o);
      checks++;
      if (o.rx !== e.rx) begin
        errors++;
        $display("FAIL random%0d_rx: mode %0d bits %0d got %h expected %h", it, md, nbits, o.rx, e.rx);
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random%0d_events: mode %0d bits %0d got %h expected %h", it, md, nbits, o, e);
      end
    end
    checks++;
    if (n_viol !== 0) begin
      errors++;
      $display("FAIL ready_without_valid: got %0d expected 0", n_viol);
    end
  endtask
  initial begin
    test_reset;
    test_mode0_stream;
    test_modes;
    test_underrun;
    test_abort;
    test_reset_mid;
    test_cs_inactive;
    test_cs_rise_sample;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
